// File: rtl/ifetch_queue.sv
// ifetch_queue: fetches 64-byte lines into a circular byte queue and presents
// a 15-byte decode window with its RIP to the decoder.
module ifetch_queue #(
    parameter int QBYTES = 128,
    parameter int LINE   = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [63:0]  entry,
    input  logic         redirect,
    input  logic [63:0]  redirect_rip,
    output logic         reqcyc,
    output logic [63:0]  req,
    output logic [12:0]  reqtag,
    input  logic         reqack,
    input  logic         respcyc,
    input  logic [63:0]  resp,
    output logic         respack,
    output logic [119:0] dec_bytes,
    output logic [7:0]   dec_avail,
    output logic [63:0]  dec_rip,
    input  logic [3:0]   consume
);
    localparam int PW = $clog2(QBYTES) + 1;
    localparam int AW = PW - 1;
    localparam logic [1:0] READ   = 2'b01;
    localparam logic [2:0] MEMORY = 3'b001;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [63:0]   fetch_rip_q, fetch_rip_d, dec_rip_q, dec_rip_d;
    logic [2:0]    skip_q, skip_d, beat_q, beat_d;
    logic          drain_q, drain_d;
    logic [7:0]    mem_q [QBYTES];
    logic [PW-1:0] avail, con, eat, wr_ptr;
    logic          beat, last, wr_en;

    assign avail   = tail_q - head_q;
    assign con     = PW'(consume);
    assign eat     = (con > avail) ? avail : con;
    assign beat    = respcyc && (state_q == WAIT || state_q == RESP);
    assign last    = beat && beat_q == 3'd7;
    assign wr_en   = beat && !drain_q && !redirect && beat_q >= skip_q;
    // Beats land 8-aligned, so bytes before the RIP in the first beat sit behind head.
    assign wr_ptr  = {tail_q[PW-1:3], 3'b000};

    assign reqcyc    = state_q == REQ;
    assign req       = fetch_rip_q;
    assign reqtag    = {READ, MEMORY, 8'h00};
    assign respack   = respcyc;
    assign dec_avail = 8'(avail);
    assign dec_rip   = dec_rip_q;

    always_comb begin
        state_d     = state_q;
        head_d      = head_q + eat;
        tail_d      = wr_en ? wr_ptr + PW'(8) : tail_q;
        fetch_rip_d = fetch_rip_q;
        dec_rip_d   = dec_rip_q + 64'(eat);
        skip_d      = skip_q;
        beat_d      = beat ? beat_q + 3'd1 : beat_q;
        drain_d     = drain_q;
        case (state_q)
            IDLE:    state_d = (!redirect && avail <= PW'(QBYTES - LINE - 8)) ? REQ : IDLE;
            REQ:     state_d = reqack ? WAIT : (redirect ? IDLE : REQ);
            WAIT:    state_d = respcyc ? RESP : WAIT;
            default: state_d = last ? IDLE : RESP;
        endcase
        if (last) begin
            drain_d     = 1'b0;
            fetch_rip_d = drain_q ? fetch_rip_q : fetch_rip_q + 64'(LINE);
            skip_d      = drain_q ? skip_q : 3'd0;
        end
        // A redirect drains whatever part of a line is still owed by the bus.
        if (redirect) begin
            head_d      = PW'(redirect_rip[2:0]);
            tail_d      = PW'(redirect_rip[2:0]);
            dec_rip_d   = redirect_rip;
            fetch_rip_d = {redirect_rip[63:6], 6'b0};
            skip_d      = redirect_rip[5:3];
            drain_d     = state_d == WAIT || state_d == RESP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            head_q      <= PW'(entry[2:0]);
            tail_q      <= PW'(entry[2:0]);
            fetch_rip_q <= {entry[63:6], 6'b0};
            dec_rip_q   <= entry;
            skip_q      <= entry[5:3];
            beat_q      <= 3'd0;
            drain_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            fetch_rip_q <= fetch_rip_d;
            dec_rip_q   <= dec_rip_d;
            skip_q      <= skip_d;
            beat_q      <= beat_d;
            drain_q     <= drain_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            for (int k = 0; k < 8; k++)
                mem_q[{wr_ptr[AW-1:3], 3'(k)}] <= resp[8*k +: 8];
    end

    always_comb begin
        dec_bytes = '0;
        for (int k = 0; k < 15; k++)
            dec_bytes[8*k +: 8] = (PW'(k) < avail) ? mem_q[AW'(head_q + PW'(k))] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!reset && !redirect)
            assert (con <= avail);
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed bus/decoder stimulus with a queue-based scoreboard.
module tb_ifetch_queue;
    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  entry;
    logic         redirect;
    logic [63:0]  redirect_rip;
    logic         reqcyc;
    logic [63:0]  req;
    logic [12:0]  reqtag;
    logic         reqack;
    logic         respcyc;
    logic [63:0]  resp;
    logic         respack;
    logic [119:0] dec_bytes;
    logic [7:0]   dec_avail;
    logic [63:0]  dec_rip;
    logic [3:0]   consume;

    ifetch_queue dut (
        .clk(clk), .reset(reset), .entry(entry), .redirect(redirect),
        .redirect_rip(redirect_rip), .reqcyc(reqcyc), .req(req), .reqtag(reqtag),
        .reqack(reqack), .respcyc(respcyc), .resp(resp), .respack(respack),
        .dec_bytes(dec_bytes), .dec_avail(dec_avail), .dec_rip(dec_rip),
        .consume(consume)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  av;
        logic [63:0] rip;
        logic [7:0]  b0;
        logic [7:0]  b14;
        logic        rc;
        string       nm;
    } win_t;

    win_t        win_q[$];
    logic [63:0] req_q[$];
    int          asserts = 0;
    int          fails = 0;
    logic        rc_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        win_t w;
        if (reqcyc && !rc_prev) begin
            if (req_q.size() == 0) begin
                chk("unexpected_req", req, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("req", req, req_q.pop_front());
                chk("reqtag", 64'(reqtag), 64'h0900);
            end
        end
        rc_prev <= reqcyc;
        if (win_q.size() != 0) begin
            w = win_q.pop_front();
            chk({w.nm, ".avail"}, 64'(dec_avail), 64'(w.av));
            chk({w.nm, ".rip"}, dec_rip, w.rip);
            chk({w.nm, ".byte0"}, 64'(dec_bytes[7:0]), 64'(w.b0));
            chk({w.nm, ".byte14"}, 64'(dec_bytes[119:112]), 64'(w.b14));
            chk({w.nm, ".reqcyc"}, 64'(reqcyc), 64'(w.rc));
            if (w.av == 8'd0)
                chk({w.nm, ".empty_lanes"}, 64'(|dec_bytes), 64'd0);
        end
    end

    task automatic ew(input logic [7:0] av, input logic [63:0] rip, input logic [7:0] b0,
                      input logic [7:0] b14, input logic rc, input string nm);
        win_t w;
        w.av = av; w.rip = rip; w.b0 = b0; w.b14 = b14; w.rc = rc; w.nm = nm;
        win_q.push_back(w);
    endtask

    function automatic logic [63:0] pat(input int k);
        return 64'h0706050403020100 + 64'h0808080808080808 * 64'(k);
    endfunction

    task automatic beat(input int k, input logic [3:0] c, input logic r, input logic [63:0] rr);
        respcyc = 1'b1; resp = pat(k); consume = c; redirect = r; redirect_rip = rr;
        @(posedge clk); #1;
        respcyc = 1'b0; consume = 4'd0; redirect = 1'b0;
    endtask

    task automatic wait_req_ack();
        int n = 0;
        while (!reqcyc && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!reqcyc) begin
            asserts++;
            fails++;
            $display("FAIL req_timeout: reqcyc stayed 0 for %0d cycles, required 1", n);
        end
        reqack = 1'b1;
        @(posedge clk); #1;
        reqack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; entry = 64'h1000_0005; redirect = 1'b0; redirect_rip = '0;
        reqack = 1'b0; respcyc = 1'b0; resp = '0; consume = 4'd0;
        req_q.push_back(64'h1000_0000);
        @(posedge clk); #1;
        ew(8'd0, 64'h1000_0005, 8'h00, 8'h00, 1'b0, "reset");
        @(posedge clk); #1;
        reset = 1'b0;
        wait_req_ack();
        ew(8'd0, 64'h1000_0005, 8'h00, 8'h00, 1'b0, "ack_drop");
        for (int k = 0; k < 8; k++) beat(k, 4'd0, 1'b0, '0);
        ew(8'd59, 64'h1000_0005, 8'h05, 8'h13, 1'b0, "line1");
        req_q.push_back(64'h1000_0040);
        consume = 4'd15;
        @(posedge clk); #1;
        ew(8'd44, 64'h1000_0014, 8'h14, 8'h22, 1'b0, "cons1");
        @(posedge clk); #1;
        ew(8'd29, 64'h1000_0023, 8'h23, 8'h31, 1'b1, "cons2");
        @(posedge clk); #1;
        consume = 4'd0;
        ew(8'd14, 64'h1000_0032, 8'h32, 8'h00, 1'b1, "cons3");
        wait_req_ack();
        for (int k = 0; k < 8; k++) beat(k, 4'd0, 1'b0, '0);
        ew(8'd78, 64'h1000_0032, 8'h32, 8'h00, 1'b0, "line2");
        repeat (3) begin
            @(posedge clk); #1;
            ew(8'd78, 64'h1000_0032, 8'h32, 8'h00, 1'b0, "stall78");
        end
        redirect = 1'b1; redirect_rip = 64'h2000_0028; consume = 4'd7;
        @(posedge clk); #1;
        redirect = 1'b0; consume = 4'd0;
        ew(8'd0, 64'h2000_0028, 8'h00, 8'h00, 1'b0, "redir_idle");
        req_q.push_back(64'h2000_0000);
        wait_req_ack();
        for (int k = 0; k < 5; k++) beat(k, 4'd0, 1'b0, '0);
        ew(8'd0, 64'h2000_0028, 8'h00, 8'h00, 1'b0, "skip_drop");
        beat(5, 4'd0, 1'b0, '0);
        ew(8'd8, 64'h2000_0028, 8'h28, 8'h00, 1'b0, "skip_first");
        beat(6, 4'd3, 1'b0, '0);
        beat(7, 4'd0, 1'b0, '0);
        ew(8'd21, 64'h2000_002B, 8'h2B, 8'h39, 1'b0, "beat_and_consume");
        req_q.push_back(64'h2000_0040);
        wait_req_ack();
        for (int k = 0; k < 3; k++) beat(k, 4'd0, 1'b0, '0);
        beat(3, 4'd0, 1'b1, 64'h3000_0010);
        ew(8'd0, 64'h3000_0010, 8'h00, 8'h00, 1'b0, "redir_drain");
        req_q.push_back(64'h3000_0000);
        for (int k = 4; k < 8; k++) beat(k, 4'd0, 1'b0, '0);
        ew(8'd0, 64'h3000_0010, 8'h00, 8'h00, 1'b0, "drained");
        wait_req_ack();
        for (int k = 0; k < 8; k++) beat(k, 4'd0, 1'b0, '0);
        ew(8'd48, 64'h3000_0010, 8'h10, 8'h1E, 1'b0, "redir_line");
        req_q.push_back(64'h3000_0040);
        wait_req_ack();
        for (int k = 0; k < 3; k++) beat(k, 4'd0, 1'b0, '0);
        #1;
        entry = 64'h4000_0000;
        reset = 1'b1;
        ew(8'd0, 64'h4000_0000, 8'h00, 8'h00, 1'b0, "async_rst");
        @(posedge clk); #1;
        reset = 1'b0;
        req_q.push_back(64'h4000_0000);
        wait_req_ack();
        for (int k = 0; k < 8; k++) beat(k, 4'd0, 1'b0, '0);
        ew(8'd64, 64'h4000_0000, 8'h00, 8'h0E, 1'b0, "full64");
        repeat (3) begin
            @(posedge clk); #1;
            ew(8'd64, 64'h4000_0000, 8'h00, 8'h0E, 1'b0, "stop64");
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        asserts++;
        if (win_q.size() != 0 || req_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: %0d window and %0d request expectations unmatched, required 0",
                     win_q.size(), req_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the decoder.
- Issues 64-byte cache-line reads on the system bus starting at a fetch RIP, collects the 8-byte response beats, and discards bytes before the RIP on the first line.
- Holds the fetched bytes in a circular byte queue and presents a 15-byte window plus the window's RIP to the decoder, which consumes 0-15 bytes per cycle.
- A redirect flushes the queue and restarts fetching at a new RIP.

Parameters:
QBYTES, 128, queue capacity in bytes; power of two, at least 128.
LINE, 64, bytes per bus read; fixed at 8 beats of 8 bytes.

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
entry  in  64  RIP loaded at reset
redirect  in  1  flush and restart fetch this cycle
redirect_rip  in  64  new fetch RIP, valid with redirect
reqcyc  out  1  bus read request valid
req  out  64  line address, RIP & ~63
reqtag  out  13  {READ, MEMORY, 8'b0}
reqack  in  1  bus accepted request
respcyc  in  1  response beat valid
resp  in  64  beat data, byte 0 in bits [7:0]
respack  out  1  equals respcyc; beats are always accepted
dec_bytes  out  120  queue bytes head..head+14; byte k in bits [8k+7:8k]
dec_avail  out  8  valid bytes in queue, 0..QBYTES
dec_rip  out  64  RIP of the byte at head
consume  in  4  bytes the decoder retires this cycle; 0..15

Behaviour:
- Reset (async) values:
  - FSM = IDLE; head = tail = entry[2:0]; fetch_rip = entry & ~63; skip = entry[5:3]; dec_rip = entry; beat_cnt = 0; drain = 0.
  - reqcyc = 0, respack = 0, dec_avail = 0, dec_bytes = 0.
- Pointers: head and tail are log2(QBYTES)+1 bits and wrap naturally. dec_avail = tail - head, computed modulo the pointer width.
- FSM states and transitions:
  - IDLE -> REQ when !redirect && (QBYTES - dec_avail) >= LINE + 8.
  - REQ: reqcyc = 1, with req and reqtag held stable. Moves to WAIT on the cycle reqack = 1. reqcyc drops the cycle after reqack.
  - WAIT -> RESP on the first respcyc; that beat is processed in the same cycle.
  - RESP: each respcyc increments beat_cnt (0..7). After beat 7: FSM -> IDLE, fetch_rip += 64, skip = 0, drain = 0.
- Beat handling (no drain, beat index b):
  - b < skip: beat is dropped, tail unchanged.
  - Otherwise: 8 bytes are written at tail..tail+7, and tail += 8.
  - Bytes below redirect_rip[2:0] in the first kept beat sit before head, so they are never visible.
- Consume:
  - head += consume and dec_rip += consume in the same cycle as any tail update.
  - consume > dec_avail is a protocol error: assertion fires, and head is clamped to tail.
- dec_bytes reflects the registered head and tail. Lanes at index >= dec_avail output 0.
- Redirect (highest priority; the consume of that cycle is ignored):
  - head = tail = redirect_rip[2:0]; dec_rip = redirect_rip; fetch_rip = redirect_rip & ~63; skip = redirect_rip[5:3]; dec_avail is 0 the next cycle.
  - In IDLE: stays IDLE.
  - In REQ before reqack: reqcyc drops and the FSM returns to IDLE; the bus never saw the old request.
  - In REQ on the same cycle as reqack, or in WAIT or RESP: drain = 1. The remaining beats of the old line are discarded, and beat_cnt still completes to 8. The new request issues only after the drain completes.
  - A second redirect during a drain only updates the target.
- Simultaneous beat write and consume in one cycle: both are applied, and avail changes by 8 - consume.
- Full: with the request guard, tail never passes head + QBYTES.

Test Plan:
- Reset with entry = 0x1000_0005, line beats 0..7 = 0x0706050403020100 + 0x0808..08*k → reqcyc next cycle with req = 0x1000_0000; after all beats, dec_avail = 59, dec_rip = 0x1000_0005, dec_bytes byte 0 = 0x05.
- Entry = 0x2000_0028 → beats 0..4 dropped, dec_avail = 24 - 0 = 24, first byte = 0x28 value.
- consume = 15 every cycle with a stalling bus → dec_avail decreases by 15 per cycle down to < 15, dec_rip advances by 15, and a refill request fires when free space is >= 72.
- Decoder stalls (consume = 0) → fetch stops at dec_avail = 64 with QBYTES = 128 (a second line would need 72 free), and reqcyc stays 0.
- Redirect to 0x3000_0010 during beat 3 of a line → beats 4..7 are discarded, and dec_avail stays 0 until the new line arrives. Then req = 0x3000_0000, and the first byte exposed is the byte at offset 0x10.
- Reset asserted mid-RESP → all outputs drop to reset values asynchronously, and the FSM restarts from entry.
